// File: rtl/alu_pkg.sv
// Shared ALU/MDU definitions: SELECT op codes, MDU state encoding, op-class helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    // 5-bit SELECT encoding shared by the single-cycle ALU and the MDU
    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_AND    = 5'b00010;
    localparam logic [4:0] ALU_OR     = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_SLL    = 5'b00101;
    localparam logic [4:0] ALU_SLT    = 5'b00110;
    localparam logic [4:0] ALU_SLTU   = 5'b00111;
    localparam logic [4:0] ALU_MUL    = 5'b01000;
    localparam logic [4:0] ALU_MULH   = 5'b01001;
    localparam logic [4:0] ALU_MULHU  = 5'b01010;
    localparam logic [4:0] ALU_MULHSU = 5'b01011;
    localparam logic [4:0] ALU_DIV    = 5'b01100;
    localparam logic [4:0] ALU_DIVU   = 5'b01101;
    localparam logic [4:0] ALU_REM    = 5'b01110;
    localparam logic [4:0] ALU_REMU   = 5'b01111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_MUL = 2'd1,
        RUN_DIV = 2'd2,
        FIN     = 2'd3
    } mdu_state_t;

    function automatic logic is_muldiv(input logic [4:0] sel);
        return (sel >= ALU_MUL) && (sel <= ALU_REMU);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring divide step.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when acc_out is captured.
// Ports: div selects the divide step; acc_in/acc_out is the 2*XLEN working register,
//        opnd is the multiplicand (multiply) or divisor (divide).
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic                div,
    input  logic [2*XLEN-1:0]   acc_in,
    input  logic [XLEN-1:0]     opnd,
    output logic [2*XLEN-1:0]   acc_out
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        // Multiply: acc = {partial high, remaining multiplier bits}; add on LSB, shift right
        sum   = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : '0);
        // Divide: acc = {remainder, dividend/quotient}; shift next dividend bit into remainder
        trial = acc_in[2*XLEN-1:XLEN-1];
        ge    = trial >= {1'b0, opnd};
        // When ge the true difference is < opnd, so the low XLEN bits are exact
        diff  = trial[XLEN-1:0] - opnd;
        if (div) begin
            acc_out = {(ge ? diff : trial[XLEN-1:0]), acc_in[XLEN-2:0], ge};
        end else begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/MULH*/DIV*/REM* unit: 32-step shift-add multiplier and restoring divider.
// Latency: DONE in the cycle after START edge + XLEN; divide-by-zero/overflow one cycle after START.
// Backpressure: BUSY high while iterating; START ignored outside IDLE; FLUSH aborts without DONE.
// Ports: CLK/RESET_N clock and async active-low reset; START/SELECT/DATA1/DATA2 request;
//        FLUSH abort; BUSY/DONE status (registered); RESULT held until the next DONE.
module mdu_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            START,
    input  logic [4:0]      SELECT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    mdu_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc, step_acc;
    logic [XLEN-1:0]   opnd;
    logic [2:0]        op;
    logic              neg;
    logic              busy_nxt, done_nxt;

    // ---------------- request decode (IDLE only) ----------------
    logic            req, sgn1, sgn2, div_zero, ovf, special, last_step;
    logic [XLEN-1:0] mag1, mag2, special_val, fin_val;

    assign req  = START && is_muldiv(SELECT);
    assign sgn1 = ((SELECT == ALU_MULH) || (SELECT == ALU_MULHSU) ||
                   (SELECT == ALU_DIV)  || (SELECT == ALU_REM)) && DATA1[XLEN-1];
    assign sgn2 = ((SELECT == ALU_MULH) || (SELECT == ALU_DIV) ||
                   (SELECT == ALU_REM)) && DATA2[XLEN-1];
    assign mag1 = sgn1 ? -DATA1 : DATA1;
    assign mag2 = sgn2 ? -DATA2 : DATA2;

    assign div_zero = SELECT[2] && (DATA2 == '0);
    assign ovf      = ((SELECT == ALU_DIV) || (SELECT == ALU_REM)) &&
                      (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (&DATA2);
    assign special  = div_zero || ovf;
    // SELECT[1] distinguishes REM* from DIV* within the divide class
    assign special_val = div_zero ? (SELECT[1] ? DATA1 : '1)
                                  : (SELECT[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    assign last_step = (cnt == CNT_W'(XLEN-1));

    // ---------------- datapath step ----------------
    mdu_step #(.XLEN(XLEN)) u_step (
        .div     (state == RUN_DIV),
        .acc_in  (acc),
        .opnd    (opnd),
        .acc_out (step_acc)
    );

    // Sign fix: negate the full product for MULH*, the selected word for DIV*/REM*
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo, rmd;
    always_comb begin
        prod_fix = neg ? -step_acc : step_acc;
        quo      = step_acc[XLEN-1:0];
        rmd      = step_acc[2*XLEN-1:XLEN];
        if (op[2]) begin
            fin_val = op[1] ? (neg ? -rmd : rmd) : (neg ? -quo : quo);
        end else begin
            fin_val = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_nxt;
            BUSY  <= busy_nxt;
            DONE  <= done_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (special)        state_nxt = FIN;
                    else if (SELECT[2]) state_nxt = RUN_DIV;
                    else                state_nxt = RUN_MUL;
                end
            end
            RUN_MUL, RUN_DIV: if (last_step) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (FLUSH) state_nxt = IDLE;
    end

    // ---------------- FSM: outputs (registered from next state) ----------------
    always_comb begin
        busy_nxt = (state_nxt == RUN_MUL) || (state_nxt == RUN_DIV);
        done_nxt = (state_nxt == FIN);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            op     <= '0;
            neg    <= 1'b0;
            RESULT <= '0;
        end else if (!FLUSH) begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op  <= SELECT[2:0];
                        // Remainder takes the dividend sign; products/quotients the XOR
                        neg <= (SELECT[2] && SELECT[1]) ? sgn1 : (sgn1 ^ sgn2);
                        cnt <= '0;
                        if (special) begin
                            RESULT <= special_val;
                        end else begin
                            acc  <= {{XLEN{1'b0}}, (SELECT[2] ? mag1 : mag2)};
                            opnd <= SELECT[2] ? mag2 : mag1;
                        end
                    end
                end
                RUN_MUL, RUN_DIV: begin
                    acc <= step_acc;
                    cnt <= cnt + 1'b1;
                    if (last_step) RESULT <= fin_val;
                end
                default: ;
            endcase
        end
    end

endmodule
